// File: rtl/uart_frame_rx_pkg.sv
// Shared types and constants for the framed UART receiver.
package uart_frame_rx_pkg;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CHK  = 2'd2;
  localparam logic [1:0] ERR_TO   = 2'd3;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload register file: one synchronous write port, one combinational read port.
module uart_frame_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_rx.sv
// Framed UART receiver: SYNC, LEN, payload, XOR checksum; buffers and drains one frame.
// Optional inter-byte timeout is enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_rx
  import uart_frame_rx_pkg::*;
#(
  parameter logic [7:0]  SYNC     = SYNC_DEFAULT,
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned TO_TICKS = 160
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx_done_tick,
  input  logic [7:0] din,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       m_last,
  input  logic       m_ready,
  output logic       err_tick,
  output logic [1:0] err_code,
  output logic       overrun_tick
);

  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_t     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] chk_q, chk_d;
  logic [7:0] rd_idx_q, rd_idx_d;
  logic       m_valid_d, m_last_d, err_tick_d, overrun_tick_d;
  logic [7:0] m_data_d;
  logic [1:0] err_code_d;

  logic          wr_en_c;
  logic [AW-1:0] rd_addr_c;
  logic [7:0]    rd_data_c;
  logic          in_frame_c;
  logic          to_fire_c;
  logic          xfer_c;

  assign in_frame_c = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
  assign xfer_c     = m_valid && m_ready;

  // Read one ahead while draining so the registered m_data is ready after each transfer.
  assign rd_addr_c = (state_q == ST_DRAIN) ? AW'(rd_idx_q + 8'd1) : '0;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int unsigned TW = (TO_TICKS > 1) ? $clog2(TO_TICKS) : 1;

  logic [TW-1:0] to_cnt_q, to_cnt_d;

  // A byte in the same cycle as the final tick wins over the timeout.
  assign to_fire_c = in_frame_c && s_tick && !rx_done_tick && (to_cnt_q == TW'(TO_TICKS - 1));

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (rx_done_tick || !in_frame_c || to_fire_c) to_cnt_d = '0;
    else if (s_tick)                               to_cnt_d = to_cnt_q + TW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  logic unused_s_tick;

  assign unused_s_tick = s_tick;
  assign to_fire_c     = 1'b0;
`endif

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (wr_en_c),
    .waddr (AW'(idx_q)),
    .wdata (din),
    .raddr (rd_addr_c),
    .rdata (rd_data_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_HUNT;
      len_q        <= '0;
      idx_q        <= '0;
      chk_q        <= '0;
      rd_idx_q     <= '0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_last       <= 1'b0;
      err_tick     <= 1'b0;
      err_code     <= ERR_NONE;
      overrun_tick <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      chk_q        <= chk_d;
      rd_idx_q     <= rd_idx_d;
      m_valid      <= m_valid_d;
      m_data       <= m_data_d;
      m_last       <= m_last_d;
      err_tick     <= err_tick_d;
      err_code     <= err_code_d;
      overrun_tick <= overrun_tick_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    idx_d          = idx_q;
    chk_d          = chk_q;
    rd_idx_d       = rd_idx_q;
    m_valid_d      = m_valid;
    m_data_d       = m_data;
    m_last_d       = m_last;
    err_tick_d     = 1'b0;
    err_code_d     = ERR_NONE;
    overrun_tick_d = 1'b0;
    wr_en_c        = 1'b0;

    if (to_fire_c) begin
      err_tick_d = 1'b1;
      err_code_d = ERR_TO;
      state_d    = ST_HUNT;
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (rx_done_tick && (din == SYNC)) state_d = ST_LEN;
        end

        ST_LEN: begin
          if (rx_done_tick) begin
            if ((din == 8'd0) || (din > 8'(MAX_LEN))) begin
              err_tick_d = 1'b1;
              err_code_d = ERR_LEN;
              state_d    = ST_HUNT;
            end else begin
              len_d   = din;
              chk_d   = din;
              idx_d   = '0;
              state_d = ST_PAYLOAD;
            end
          end
        end

        ST_PAYLOAD: begin
          if (rx_done_tick) begin
            wr_en_c = 1'b1;
            chk_d   = chk_q ^ din;
            idx_d   = idx_q + 8'd1;
            if (idx_q + 8'd1 == len_q) state_d = ST_CHK;
          end
        end

        ST_CHK: begin
          if (rx_done_tick) begin
            if (din == chk_q) begin
              state_d   = ST_DRAIN;
              rd_idx_d  = '0;
              m_valid_d = 1'b1;
              m_data_d  = rd_data_c;
              m_last_d  = (len_q == 8'd1);
            end else begin
              err_tick_d = 1'b1;
              err_code_d = ERR_CHK;
              state_d    = ST_HUNT;
            end
          end
        end

        ST_DRAIN: begin
          overrun_tick_d = rx_done_tick;
          if (xfer_c) begin
            if (rd_idx_q + 8'd1 == len_q) begin
              state_d   = ST_HUNT;
              rd_idx_d  = '0;
              m_valid_d = 1'b0;
              m_data_d  = '0;
              m_last_d  = 1'b0;
            end else begin
              rd_idx_d = rd_idx_q + 8'd1;
              m_data_d = rd_data_c;
              m_last_d = (rd_idx_q + 8'd2 == len_q);
            end
          end
        end

        default: state_d = ST_HUNT;
      endcase
    end
  end

endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 Parameter SYNC, default 8'hA5, frame start byte.
REQ-002 Parameter MAX_LEN, default 16, maximum payload bytes per frame (range 1..255).
REQ-003 Parameter TO_TICKS, default 160, inter-byte timeout in s_tick pulses.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-006 s_tick  in  1  16x-oversample baud tick, used only for the timeout.
REQ-007 rx_done_tick  in  1  one-cycle strobe: din holds a received byte.
REQ-008 din  in  8  received byte.
REQ-009 m_valid  out  1  payload byte available on m_data.
REQ-010 m_data  out  8  payload byte.
REQ-011 m_last  out  1  m_data is the final byte of the frame.
REQ-012 m_ready  in  1  consumer accepts the byte; transfer occurs when m_valid & m_ready.
REQ-013 err_tick  out  1  one-cycle pulse when a frame is discarded.
REQ-014 err_code  out  2  cause, valid with err_tick: 1 = bad length, 2 = checksum, 3 = timeout.
REQ-015 overrun_tick  out  1  one-cycle pulse when a byte arrives during DRAIN.

Function
REQ-016 Frame format: SYNC, LEN, LEN payload bytes, CHK; CHK = XOR of LEN and all payload bytes.
REQ-017 The FSM shall have states HUNT, LEN, PAYLOAD, CHK and DRAIN.
REQ-018 HUNT: a byte equal to SYNC goes to LEN; any other byte is ignored silently.
REQ-019 LEN: LEN of 0 or LEN > MAX_LEN gives err_code 1 and returns to HUNT; otherwise latch LEN, seed the checksum with LEN, clear the index and go to PAYLOAD.
REQ-020 PAYLOAD: each byte is written to buffer[index], XORed into the checksum and increments index; after byte LEN go to CHK.
REQ-021 CHK: a byte equal to the checksum goes to DRAIN; a mismatch gives err_code 2 and returns to HUNT.
REQ-022 DRAIN: m_valid=1 with m_data=buffer[rd_idx]; each accepted transfer increments rd_idx; m_last=1 when rd_idx==LEN-1; accepting the last byte returns to HUNT.
REQ-023 m_valid shall be asserted no later than the cycle after DRAIN is entered; m_data and m_last shall be held stable while m_valid & ~m_ready.
REQ-024 An rx_done_tick in DRAIN shall pulse overrun_tick; the byte is dropped and drain continues.
REQ-025 In LEN, PAYLOAD or CHK, reaching TO_TICKS s_tick pulses since the last byte gives err_code 3 and returns to HUNT.
REQ-026 The timeout counter shall clear on every rx_done_tick and shall not count in HUNT or DRAIN.
REQ-027 If rx_done_tick and the final timeout s_tick occur in the same cycle, the byte wins and no timeout is raised.
REQ-028 err_tick and overrun_tick shall be registered one-cycle pulses, asserted the cycle after the causing event.

Reset
REQ-029 Reset (reset=0), at any time including mid-frame or mid-drain, shall force state HUNT, all counters and the checksum to 0, and m_valid, m_last, err_tick, overrun_tick and err_code to 0; m_data shall be 0.
REQ-030 Buffer contents need not be reset.

Configuration
REQ-031 With UART_FRAME_TIMEOUT_EN defined, REQ-025 to REQ-027 apply; without it the timeout counter is absent, s_tick is ignored, and err_code 3 shall never occur.

Structure
REQ-032 A shared package shall hold the state encodings, the err_code constants (ERR_LEN, ERR_CHK, ERR_TO) and the default SYNC value.
REQ-033 The payload storage shall be one sub-module, uart_frame_buf: MAX_LEN x 8 register file with one synchronous write port and one combinational read port.

Verification
REQ-034 Frame A5 03 11 22 33 03 with m_ready=1: m_data 11, 22, 33 on three transfers, m_last only with 33, no err_tick.
REQ-035 Frame A5 02 10 20 00: err_tick with err_code 2, no m_valid; a following valid frame is delivered correctly.
REQ-036 A5 00, then A5 11 (17 > MAX_LEN): two err_tick pulses, each with err_code 1.
REQ-037 A5 02 10, then 160 s_tick pulses with no byte: err_tick with err_code 3 (timeout build); nothing happens with the macro undefined.
REQ-038 Valid 2-byte frame with m_ready=0 for 20 cycles while byte 5A arrives: overrun_tick pulses, m_data held stable, both payload bytes delivered after m_ready=1.
REQ-039 reset pulsed low during PAYLOAD: all outputs 0; a frame sent afterwards is received normally.
